// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and width helper for the PWM generator
package pwm_pkg;

    localparam int         PWM_STEPS       = 256;
    localparam logic [7:0] DUTY_FULL       = 8'hFF;
    localparam int         CLK_DIV_DEFAULT = 3000;

    // Prescaler counter width; a divider of 1 still needs a 1-bit counter
    function automatic int div_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

    localparam int DIV_W = div_width(CLK_DIV_DEFAULT);

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler and 8-bit step counter for the PWM period
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic       wrap,
    output logic [7:0] step_cnt
);

    localparam int              DW        = div_width(CLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [7:0]      STEP_LAST = 8'(PWM_STEPS - 1);

    logic [DW-1:0] div_cnt;

    // tick marks the last clk of each step; wrap marks the last clk of the period
    assign tick = (div_cnt == DIV_LAST);
    assign wrap = tick && (step_cnt == STEP_LAST);

    // Prescaler: count 0..CLK_DIV-1 and restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Step counter advances once per tick and rolls over naturally 255 -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= 8'd0;
        end else if (tick) begin
            step_cnt <= step_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - 16-pin static/PWM output driver with double-buffered duty
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    logic        tick;
    logic        wrap;
    logic [7:0]  step_cnt;
    logic [7:0]  duty_active;
    logic        pwm_signal;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .wrap     (wrap),
        .step_cnt (step_cnt)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Full-scale duty is forced high so 0xFF never dips for the last step
    assign pwm_signal = (duty_active == DUTY_FULL) || (step_cnt < duty_active);

    // Duty shadow only reloads on the period wrap so a running period never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= 8'd0;
        end else if (wrap) begin
            duty_active <= pwm_duty_cycle;
        end
    end

    // Registered pin mux and period boundary pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= en_out & (~en_pwm | {16{pwm_signal}});
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - self-checking bench for pwm_generator with a cycle-count reference model
module tb_pwm_generator;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = CLK_DIV * 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] pwm_out;
    logic        period_start;

    int checks = 0;
    int errors = 0;

    pwm_generator #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .pwm_out         (pwm_out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // Reference: position in the period follows from the number of clks since reset
    int unsigned n       = 0;
    logic [7:0]  duty_m  = 8'h00;
    logic [15:0] exp_out = 16'h0000;
    logic        exp_ps  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n       = 0;
            duty_m  = 8'h00;
            exp_out = 16'h0000;
            exp_ps  = 1'b0;
        end else begin
            int  step;
            bit  last_clk_of_period;
            bit  high;
            step               = (n / CLK_DIV) % 256;
            last_clk_of_period = ((n % PERIOD) == PERIOD - 1);
            high               = (duty_m == 8'hFF) || (step < duty_m);
            exp_out            = en_out & (~en_pwm | {16{high}});
            exp_ps             = last_clk_of_period;
            if (last_clk_of_period) duty_m = duty;
            n++;
        end
    end

    // Every cycle, away from the active edge, the pins must match the model
    always @(negedge clk) begin
        checks++;
        assert (pwm_out === exp_out) else begin
            errors++;
            $error("FAIL model_pwm_out t=%0t observed=%h expected=%h", $time, pwm_out, exp_out);
        end
        checks++;
        assert (period_start === exp_ps) else begin
            errors++;
            $error("FAIL model_period_start t=%0t observed=%b expected=%b", $time, period_start, exp_ps);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ps();
        bit found = 1'b0;
        for (int k = 0; k < PERIOD + 200 && !found; k++) begin
            @(negedge clk);
            if (period_start === 1'b1) found = 1'b1;
        end
        chk("period_start_seen", 32'(found), 32'd1);
    endtask

    initial begin
        int hi;
        int bad;
        int pulses;
        int last_pulse;
        int gap_bad;
        logic prev_ps;

        // Reset hold with every input driven high
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'hFF;
        repeat (5) @(negedge clk);
        chk("reset_pwm_out", 32'(pwm_out), 32'h0000);
        chk("reset_period_start", 32'(period_start), 32'd0);

        // Static high pins
        rst_n  = 1'b1;
        en_out = 16'h0001;
        en_pwm = 16'h0000;
        duty   = 8'h80;
        @(negedge clk);
        chk("static_pin0", 32'(pwm_out), 32'h0001);
        en_out = 16'h8000;
        @(negedge clk);
        chk("static_pin15", 32'(pwm_out), 32'h8000);

        // 50% duty on pins 7..0
        en_out = 16'h00FF;
        en_pwm = 16'h00FF;
        wait_ps();
        hi = 0; bad = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[7:0] == 8'hFF) hi++;
            if (pwm_out[15:8] != 8'h00) bad++;
            if (i == 0) chk("duty80_first_high", 32'(pwm_out[7:0]), 32'hFF);
            if (i == 512) chk("duty80_low_half", 32'(pwm_out[7:0]), 32'h00);
        end
        chk("duty80_high_clks", 32'(hi), 32'd512);
        chk("duty80_upper_low", 32'(bad), 32'd0);

        // Full scale: no dip across three periods
        duty = 8'hFF;
        wait_ps();
        bad = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[7:0] != 8'hFF) bad++;
        end
        chk("dutyFF_never_low", 32'(bad), 32'd0);

        // Zero duty
        duty = 8'h00;
        wait_ps();
        bad = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[7:0] != 8'h00) bad++;
        end
        chk("duty00_never_high", 32'(bad), 32'd0);

        // Mid-period duty write is deferred to the next period
        duty = 8'h40;
        wait_ps();
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[0]) hi++;
            if (i == 400) duty = 8'hC0;
        end
        chk("shadow_current_period", 32'(hi), 32'd256);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[0]) hi++;
        end
        chk("shadow_next_period", 32'(hi), 32'd768);

        // Asynchronous reset mid-period
        en_out = 16'h00FF;
        en_pwm = 16'h0000;
        @(negedge clk);
        chk("pre_reset_static", 32'(pwm_out), 32'h00FF);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_pwm_out", 32'(pwm_out), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Outputs disabled: pins stay low while the period still runs
        en_out = 16'h0000;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        bad = 0; pulses = 0; last_pulse = -1; gap_bad = 0; prev_ps = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 100; i++) begin
            @(negedge clk);
            if (pwm_out != 16'h0000) bad++;
            if (period_start === 1'b1) begin
                if (prev_ps) gap_bad++;
                if (last_pulse >= 0 && (i - last_pulse) != PERIOD) gap_bad++;
                last_pulse = i;
                pulses++;
            end
            prev_ps = period_start;
        end
        chk("disabled_pins_low", 32'(bad), 32'd0);
        chk("period_start_pulses", 32'(pulses), 32'd2);
        chk("period_start_spacing_width", 32'(gap_bad), 32'd0);

        // Randomized configuration changes, checked cycle by cycle against the model
        for (int r = 0; r < 25; r++) begin
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       duty = 8'h00;
                1:       duty = 8'hFF;
                default: duty = 8'($urandom_range(0, 255));
            endcase
            repeat ($urandom_range(1, 700)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Consumes the five configuration registers written by the SPI register-file stage and drives 16 output pins. Each pin is statically low, statically high, or a shared PWM waveform with a 256-step period and 8-bit duty cycle. A programmable prescaler sets the PWM frequency. Duty updates are double-buffered so that changes never glitch a running period.

## Interface
Parameters:
- CLK_DIV, default 3000: clk cycles per PWM step; legal range ≥1 (at 10 MHz this gives ≈13 Hz × 256 steps ≈ 3.3 kHz step rate).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM select, pins 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- pwm_out  output  16  pin drive; bit i is pin i
- period_start  output  1  one-clk pulse at each PWM period boundary

## Operation
- en_out[15:0] = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm[15:0] = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
- Pin i, per cycle:
  - en_out[i]=0 → 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → pwm_signal.
- Prescaler: div_cnt counts 0..CLK_DIV-1, then wraps to 0. tick=1 when div_cnt==CLK_DIV-1. When CLK_DIV=1, tick is high every cycle.
- Step counter: step_cnt is 8 bits and increments on tick. It wraps 255→0, so one period is 256 ticks.
- Duty shadow: duty_active loads pwm_duty_cycle only on the tick where step_cnt wraps 255→0. It holds its value at all other times.
  - Mid-period writes take effect at the next period.
  - The first period after reset uses duty_active=0 (pins low).
- pwm_signal = (duty_active==8'hFF) | (step_cnt < duty_active):
  - 0x00 → always low.
  - 0xFF → always high (true 100%, no 1-step dip).
  - Otherwise high for duty_active steps out of 256.
- Enable and select inputs are not shadowed. Changes take effect on pwm_out one clk later.

## Timing
- Reset (async assert): div_cnt=0, step_cnt=0, duty_active=0, pwm_out=16'h0000, period_start=0. Release is synchronous to clk.
- pwm_out is registered: pwm_out <= en_out & (~en_pwm | {16{pwm_signal}}), computed from the current-cycle inputs and registers. Latency from input change to pin is 1 clk.
- period_start <= tick & (step_cnt==255).
  - It is high for exactly one clk, in the cycle where step_cnt first reads 0.
  - pwm_out reflects the new period (new duty_active) one clk after period_start.
- Simultaneous events:
  - A duty write on the same clk as the wrap tick is captured into duty_active.
  - An enable change on the wrap tick applies to the output alongside the new duty.
- Reset mid-period forces pwm_out=0 immediately (asynchronously) and restarts the period from step 0.
- Rising edges of pwm_out for a PWM pin occur only at period boundaries. Falling edges occur only at step boundaries.

## Structure
- Package pwm_pkg:
  - PWM_STEPS=256
  - DUTY_FULL=8'hFF
  - CLK_DIV_DEFAULT=3000
  - derived width DIV_W=$clog2(CLK_DIV) with a minimum of 1
- Sub-module pwm_timebase contains the prescaler, step counter, the tick output and the wrap output.
- The top level contains the duty shadow register, the compare logic, the per-pin mux and the output registers.

## Test plan
Run the bench with CLK_DIV=4, so one period is 1024 clk.
- Reset hold, all inputs 0xFF → pwm_out=0x0000, period_start=0. Assert rst_n low mid-period → pwm_out=0 immediately.
- en_out=0x0001, en_pwm=0x0000 → pwm_out[0]=1 one clk after the inputs are applied, all other bits 0. Set en_out=0x8000 → only pwm_out[15]=1.
- en_out=en_pwm=0x00FF, duty=0x80 → after the first period_start, bits 7..0 are high for 512 clk then low for 512 clk, repeating. Pins 15..8 are low.
- duty=0xFF → PWM pins stay constantly high across 3 periods. duty=0x00 → PWM pins stay constantly low.
- duty=0x40 is running; write 0xC0 at step 100 → the current period stays high for 256 clk total. The next period is high for 768 clk.
- en_pwm=0xFFFF, en_out=0x0000, duty=0x80 → pwm_out stays 0x0000. period_start pulses every 1024 clk and is exactly 1 clk wide.
